// File: rtl/phase_vec_serial_loader.sv
// phase_vec_serial_loader
// Serial-to-parallel front end for the phase/frequency vector SRAM interface.
// Shifts an MSB-first bit stream into DATA_WIDTH-bit words and strobes each
// completed word into the SRAM interface. It stops after a programmed word
// count, which is clamped to DEPTH, and then pulses done for one cycle.
// An abort or reset discards any partially assembled word.
module phase_vec_serial_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 2048
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] num_words,
    input  logic                  sdi,
    input  logic                  sdi_valid,
    output logic                  load,
    output logic                  wdata_valid,
    output logic [DATA_WIDTH-1:0] wdata_out,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] words_written
);

    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0]      LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] DEPTH_CAP  = ADDR_WIDTH'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ZERO_WORDS = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ONE_WORD   = ADDR_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA  = {DATA_WIDTH{1'b0}};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Requests larger than the SRAM depth are cut to DEPTH.
    function automatic logic [ADDR_WIDTH-1:0] clamp_target(input logic [ADDR_WIDTH-1:0] req);
        logic [ADDR_WIDTH-1:0] res;
        if (req > DEPTH_CAP) begin
            res = DEPTH_CAP;
        end else begin
            res = req;
        end
        return res;
    endfunction

    logic [1:0]            state_r,         state_s;
    logic [ADDR_WIDTH-1:0] target_r,        target_s;
    logic [DATA_WIDTH-1:0] shreg_r,         shreg_s;
    logic [CNT_W-1:0]      bit_cnt_r,       bit_cnt_s;
    logic                  load_r,          load_s;
    logic                  wdata_valid_r,   wdata_valid_s;
    logic [DATA_WIDTH-1:0] wdata_out_r,     wdata_out_s;
    logic                  busy_r,          busy_s;
    logic                  done_r,          done_s;
    logic [ADDR_WIDTH-1:0] words_written_r, words_written_s;
    logic [DATA_WIDTH-1:0] word_s;
    logic [ADDR_WIDTH-1:0] req_target_s;

    // Next-state and next-output computation for the IDLE/LOAD/DONE sequencer.
    always_comb begin
        state_s         = state_r;
        target_s        = target_r;
        shreg_s         = shreg_r;
        bit_cnt_s       = bit_cnt_r;
        load_s          = 1'b0;
        wdata_valid_s   = 1'b0;
        wdata_out_s     = wdata_out_r;
        busy_s          = 1'b0;
        done_s          = 1'b0;
        words_written_s = words_written_r;
        word_s          = {shreg_r[DATA_WIDTH-2:0], sdi};
        req_target_s    = clamp_target(num_words);

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    target_s        = req_target_s;
                    words_written_s = ZERO_WORDS;
                    bit_cnt_s       = CNT_ZERO;
                    shreg_s         = ZERO_DATA;
                    busy_s          = 1'b1;
                    if (req_target_s == ZERO_WORDS) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_LOAD;
                        load_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_LOAD: begin
                if (abort) begin
                    // Abort beats a completing bit: no strobe, partial word dropped.
                    state_s   = ST_IDLE;
                    shreg_s   = ZERO_DATA;
                    bit_cnt_s = CNT_ZERO;
                end else if (words_written_r == target_r) begin
                    // Final strobe is on the interface this cycle; further bits are ignored.
                    state_s = ST_DONE;
                    busy_s  = 1'b1;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_LOAD;
                    load_s  = 1'b1;
                    busy_s  = 1'b1;
                    if (sdi_valid) begin
                        shreg_s = word_s;
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_s       = CNT_ZERO;
                            wdata_valid_s   = 1'b1;
                            wdata_out_s     = word_s;
                            words_written_s = words_written_r + ONE_WORD;
                        end else begin
                            bit_cnt_s = bit_cnt_r + CNT_ONE;
                        end
                    end else begin
                        shreg_s   = shreg_r;
                        bit_cnt_s = bit_cnt_r;
                    end
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            target_r        <= ZERO_WORDS;
            shreg_r         <= ZERO_DATA;
            bit_cnt_r       <= CNT_ZERO;
            load_r          <= 1'b0;
            wdata_valid_r   <= 1'b0;
            wdata_out_r     <= ZERO_DATA;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
            words_written_r <= ZERO_WORDS;
        end else begin
            state_r         <= state_s;
            target_r        <= target_s;
            shreg_r         <= shreg_s;
            bit_cnt_r       <= bit_cnt_s;
            load_r          <= load_s;
            wdata_valid_r   <= wdata_valid_s;
            wdata_out_r     <= wdata_out_s;
            busy_r          <= busy_s;
            done_r          <= done_s;
            words_written_r <= words_written_s;
        end
    end

    assign load          = load_r;
    assign wdata_valid   = wdata_valid_r;
    assign wdata_out     = wdata_out_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign words_written = words_written_r;

endmodule

// File: tb/tb_phase_vec_serial_loader.sv
// Testbench for phase_vec_serial_loader: randomized serial streams checked
// against expected word lists and expected strobe/done/load timing.
module tb_phase_vec_serial_loader;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          rst, start, abort, sdi, sdi_valid;
    logic [AW-1:0] num_words;
    logic          load, wdata_valid, busy, done;
    logic [DW-1:0] wdata_out;
    logic [AW-1:0] words_written;

    phase_vec_serial_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_words(num_words),
        .sdi(sdi), .sdi_valid(sdi_valid), .load(load), .wdata_valid(wdata_valid),
        .wdata_out(wdata_out), .busy(busy), .done(done), .words_written(words_written)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_checks = 0;
    int n_pass = 0;
    int start_cyc;

    // Cycle index n covers the interval between posedge n and posedge n+1.
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] mon_vals[$];
    int            mon_cyc[$];
    int            mon_done[$];
    int            load_cnt, load_first, load_last, busy_cnt;
    logic [DW-1:0] exp_words[$];
    int            exp_cyc[$];

    // Records every strobe, done pulse and load/busy cycle seen on the outputs.
    always @(negedge clk) begin
        if (wdata_valid === 1'b1) begin
            mon_vals.push_back(wdata_out);
            mon_cyc.push_back(cyc);
        end
        if (done === 1'b1) mon_done.push_back(cyc);
        if (load === 1'b1) begin
            if (load_first < 0) load_first <= cyc;
            load_last <= cyc;
            load_cnt  <= load_cnt + 1;
        end
        if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    end

    task automatic clear_mon();
        mon_vals.delete(); mon_cyc.delete(); mon_done.delete();
        load_cnt = 0; load_first = -1; load_last = -1; busy_cnt = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0; sdi_valid = 1'b0; sdi = 1'($urandom);
        end
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1; num_words = AW'(n); sdi_valid = 1'b0; start_cyc = cyc;
    endtask

    // Streams exp_words MSB-first (first `limit` valid bits, or all if limit<0),
    // then extra random bits; notes the cycle of each word-completing bit.
    task automatic feed(input int gap_mode, input int limit_in, input int extra_bits, input int start_every);
        int total, limit, i, k;
        logic v;
        logic [DW-1:0] w;
        total = exp_words.size() * DW;
        limit = (limit_in >= 0) ? limit_in : total;
        exp_cyc.delete();
        i = 0; k = 0;
        while (i < limit + extra_bits) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (start_every > 0 && (k % start_every) == 0 && i < limit - 64) begin
                start = 1'b1; num_words = AW'(5);
            end
            if (gap_mode == 0)      v = 1'b1;
            else if (gap_mode == 1) v = ((k % 2) == 1);
            else                    v = 1'($urandom_range(0, 1));
            sdi_valid = v;
            if (v && i < limit && i < total) begin
                w = exp_words[i / DW];
                sdi = w[DW - 1 - (i % DW)];
                if ((i % DW) == DW - 1) exp_cyc.push_back(cyc);
                i++;
            end else begin
                sdi = 1'($urandom);
                if (v) i++;
            end
        end
        @(negedge clk);
        sdi_valid = 1'b0; start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            start = 1'($urandom); num_words = AW'(3); sdi_valid = 1'b1; sdi = 1'($urandom);
        end
        n_checks++;
        if ({load, wdata_valid, busy, done} !== 4'b0000)
            $display("FAIL reset_flags: got %b expected 0000", {load, wdata_valid, busy, done});
        else n_pass++;
        n_checks++;
        if (wdata_out !== 16'h0000 || words_written !== 12'd0)
            $display("FAIL reset_data: got wdata_out=%0h words_written=%0d expected 0/0", wdata_out, words_written);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0; start = 1'b0; sdi_valid = 1'b0;
        idle(2);
    endtask

    // Caller fills exp_words with the words the DUT should write.
    task automatic test_stream(input string tag, input int n_req, input int gap_mode,
                               input int extra_bits, input int start_every);
        int n, lc;
        n = exp_words.size();
        clear_mon();
        do_start(n_req);
        feed(gap_mode, -1, extra_bits, start_every);
        idle(5);
        lc = exp_cyc[n - 1];
        n_checks++;
        if (mon_vals.size() !== n)
            $display("FAIL %s strobe_count: got %0d expected %0d", tag, mon_vals.size(), n);
        else n_pass++;
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (i >= mon_vals.size())
                $display("FAIL %s word%0d: got none expected %h", tag, i, exp_words[i]);
            else if (mon_vals[i] !== exp_words[i] || mon_cyc[i] !== exp_cyc[i] + 1)
                $display("FAIL %s word%0d: got %h@%0d expected %h@%0d", tag, i,
                         mon_vals[i], mon_cyc[i], exp_words[i], exp_cyc[i] + 1);
            else n_pass++;
        end
        n_checks++;
        if (mon_done.size() !== 1 || mon_done[0] !== lc + 2)
            $display("FAIL %s done: got %0d pulses first@%0d expected 1@%0d", tag, mon_done.size(),
                     (mon_done.size() > 0) ? mon_done[0] : -1, lc + 2);
        else n_pass++;
        n_checks++;
        if (load_first !== start_cyc + 1 || load_last !== lc + 1 || load_cnt !== lc + 1 - start_cyc)
            $display("FAIL %s load_window: got %0d..%0d (%0d) expected %0d..%0d", tag,
                     load_first, load_last, load_cnt, start_cyc + 1, lc + 1);
        else n_pass++;
        n_checks++;
        if (busy_cnt !== load_cnt + 1)
            $display("FAIL %s busy_cycles: got %0d expected %0d", tag, busy_cnt, load_cnt + 1);
        else n_pass++;
        n_checks++;
        if (words_written !== AW'(n))
            $display("FAIL %s words_written: got %0d expected %0d", tag, words_written, n);
        else n_pass++;
    endtask

    task automatic test_zero_words();
        clear_mon();
        do_start(0);
        idle(4);
        n_checks++;
        if (mon_vals.size() !== 0 || load_cnt !== 0)
            $display("FAIL zero strobes_load: got %0d strobes %0d load cycles expected 0/0", mon_vals.size(), load_cnt);
        else n_pass++;
        n_checks++;
        if (mon_done.size() !== 1 || mon_done[0] !== start_cyc + 1 || busy_cnt !== 1)
            $display("FAIL zero done_busy: got %0d done %0d busy expected 1@%0d busy 1",
                     mon_done.size(), busy_cnt, start_cyc + 1);
        else n_pass++;
        n_checks++;
        if (words_written !== 12'd0)
            $display("FAIL zero words_written: got %0d expected 0", words_written);
        else n_pass++;
    endtask

    task automatic test_abort();
        int ac;
        logic [DW-1:0] w;
        exp_words.delete();
        exp_words.push_back(16'($urandom)); exp_words.push_back(16'($urandom));
        clear_mon();
        do_start(2);
        feed(0, DW + 7, 0, 0);
        @(negedge clk);
        abort = 1'b1; sdi_valid = 1'b1; sdi = 1'($urandom); ac = cyc;
        idle(4);
        n_checks++;
        if (mon_vals.size() !== 1 || mon_vals[0] !== exp_words[0] || mon_cyc[0] !== exp_cyc[0] + 1)
            $display("FAIL abort strobe: got %0d strobes first %h expected 1 of %h",
                     mon_vals.size(), (mon_vals.size() > 0) ? mon_vals[0] : 16'h0, exp_words[0]);
        else n_pass++;
        n_checks++;
        if (mon_done.size() !== 0 || load_last !== ac)
            $display("FAIL abort done_load: got %0d done load_last=%0d expected 0 done load_last=%0d",
                     mon_done.size(), load_last, ac);
        else n_pass++;
        n_checks++;
        if (words_written !== 12'd1)
            $display("FAIL abort words_written: got %0d expected 1", words_written);
        else n_pass++;
        exp_words.delete();
        exp_words.push_back(16'($urandom));
        test_stream("after_abort", 1, 0, 0, 0);
        // Abort in the same cycle as a word-completing bit: no strobe.
        w = 16'($urandom);
        exp_words.delete(); exp_words.push_back(w);
        clear_mon();
        do_start(1);
        feed(0, DW - 1, 0, 0);
        @(negedge clk);
        abort = 1'b1; sdi_valid = 1'b1; sdi = w[0]; ac = cyc;
        idle(4);
        n_checks++;
        if (mon_vals.size() !== 0 || mon_done.size() !== 0 || load_last !== ac || words_written !== 12'd0)
            $display("FAIL abort_last_bit: got %0d strobes %0d done load_last=%0d ww=%0d expected 0/0/%0d/0",
                     mon_vals.size(), mon_done.size(), load_last, words_written, ac);
        else n_pass++;
    endtask

    task automatic test_rst_mid_word();
        exp_words.delete();
        exp_words.push_back(16'($urandom)); exp_words.push_back(16'($urandom));
        do_start(2);
        feed(0, DW + 8, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({load, wdata_valid, busy, done} !== 4'b0000 || wdata_out !== 16'h0000 || words_written !== 12'd0)
            $display("FAIL rst_mid state: got flags=%b wdata_out=%h ww=%0d expected 0000/0/0",
                     {load, wdata_valid, busy, done}, wdata_out, words_written);
        else n_pass++;
        idle(2);
        exp_words.delete();
        exp_words.push_back(16'h1234);
        test_stream("rst_mid_reload", 1, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; sdi = 1'b0; sdi_valid = 1'b0; num_words = '0;
        clear_mon();
        test_reset();

        exp_words.delete();
        exp_words.push_back(16'hA5A5); exp_words.push_back(16'h0001); exp_words.push_back(16'hFFFF);
        test_stream("contiguous", 3, 0, 20, 0);

        test_zero_words();

        exp_words.delete();
        for (int i = 0; i < 2; i++) exp_words.push_back(16'($urandom));
        test_stream("gapped", 2, 1, 0, 0);

        for (int r = 0; r < 3; r++) begin
            int n;
            n = $urandom_range(1, 6);
            exp_words.delete();
            for (int i = 0; i < n; i++) exp_words.push_back(16'($urandom));
            test_stream("random_gaps", n, 2, 8, 0);
        end

        test_abort();
        test_rst_mid_word();

        exp_words.delete();
        for (int i = 0; i < DEPTH; i++) exp_words.push_back(16'($urandom));
        test_stream("clamp", 4095, 0, 32, 997);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
